// File: rtl/argon_regfile_dp.sv
`default_nettype none
// ============================================================================
// Module  : argon_regfile_dp
// Brief   : Parametrised register file: two registered read ports, one write
//           port, multi-cycle hardware clear. Register 0 reads as zero.
//           Optional write-to-read bypass: define ARGON_REGFILE_BYPASS_EN.
// Revision: 1.0 - initial release
// ============================================================================
module argon_regfile_dp #(
    parameter  int DATA_W   = 16,
    parameter  int NUM_REGS = 16,
    localparam int IDX_W    = $clog2(NUM_REGS)
) (
    input  logic                 i_Clk,
    input  logic                 i_Reset_n,
    input  logic                 i_selLatch,
    input  logic [3*IDX_W-1:0]   i_selData,
    input  logic                 i_readA,
    input  logic                 i_readB,
    input  logic                 i_writeC,
    input  logic [DATA_W-1:0]    i_wrData,
    input  logic                 i_clear,
    output logic [DATA_W-1:0]    o_dataA,
    output logic                 o_validA,
    output logic [DATA_W-1:0]    o_dataB,
    output logic                 o_validB,
    output logic                 o_busy
);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [IDX_W-1:0]    r_clr_cnt;
    logic [IDX_W-1:0]    w_clr_cnt_nxt;

    logic [IDX_W-1:0]    r_idx_a;
    logic [IDX_W-1:0]    r_idx_b;
    logic [IDX_W-1:0]    r_idx_c;

    // Register 0 has no storage; it is synthesised as a constant zero on read.
    logic [DATA_W-1:0]   r_regs [1:NUM_REGS-1];

    logic                w_idle_ops;
    logic                w_wr_en;
    logic [DATA_W-1:0]   w_rd_a;
    logic [DATA_W-1:0]   w_rd_b;

    function automatic logic idx_ok(input logic [IDX_W-1:0] idx);
        return (idx != '0) && (int'(idx) < NUM_REGS);
    endfunction

    function automatic logic [DATA_W-1:0] rd_word(input logic [IDX_W-1:0] idx);
        logic [DATA_W-1:0] v;
        v = '0;
        if (idx_ok(idx)) begin
            v = r_regs[idx];
        end
        return v;
    endfunction

    // Strobes are only honoured in IDLE and not in the cycle that starts a clear.
    assign w_idle_ops = (r_state == IDLE) && !i_clear;
    assign w_wr_en    = w_idle_ops && i_writeC && idx_ok(r_idx_c);
    assign o_busy     = (r_state == CLEAR);

    always_comb begin
        w_rd_a = rd_word(r_idx_a);
        w_rd_b = rd_word(r_idx_b);
`ifdef ARGON_REGFILE_BYPASS_EN
        if (w_wr_en && (r_idx_a == r_idx_c)) begin
            w_rd_a = i_wrData;
        end
        if (w_wr_en && (r_idx_b == r_idx_c)) begin
            w_rd_b = i_wrData;
        end
`endif
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_clr_cnt_nxt = r_clr_cnt;
        case (r_state)
            IDLE: begin
                if (i_clear) begin
                    w_state_nxt   = CLEAR;
                    w_clr_cnt_nxt = IDX_W'(1);
                end
            end
            CLEAR: begin
                if (r_clr_cnt == IDX_W'(NUM_REGS - 1)) begin
                    w_state_nxt   = IDLE;
                    w_clr_cnt_nxt = '0;
                end else begin
                    w_clr_cnt_nxt = r_clr_cnt + IDX_W'(1);
                end
            end
            default: begin
                w_state_nxt   = IDLE;
                w_clr_cnt_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge i_Clk or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            r_state   <= IDLE;
            r_clr_cnt <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_clr_cnt <= w_clr_cnt_nxt;
        end
    end

    always_ff @(posedge i_Clk or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            r_idx_a <= '0;
            r_idx_b <= '0;
            r_idx_c <= '0;
        end else if (w_idle_ops && i_selLatch) begin
            r_idx_a <= i_selData[IDX_W-1:0];
            r_idx_b <= i_selData[2*IDX_W-1:IDX_W];
            r_idx_c <= i_selData[3*IDX_W-1:2*IDX_W];
        end
    end

    always_ff @(posedge i_Clk or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            for (int i = 1; i < NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (r_state == CLEAR) begin
            r_regs[r_clr_cnt] <= '0;
        end else if (w_wr_en) begin
            r_regs[r_idx_c] <= i_wrData;
        end
    end

    always_ff @(posedge i_Clk or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            o_dataA  <= '0;
            o_validA <= 1'b0;
            o_dataB  <= '0;
            o_validB <= 1'b0;
        end else begin
            o_validA <= w_idle_ops && i_readA;
            o_validB <= w_idle_ops && i_readB;
            if (w_idle_ops && i_readA) begin
                o_dataA <= w_rd_a;
            end
            if (w_idle_ops && i_readB) begin
                o_dataB <= w_rd_b;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_argon_regfile_dp.sv
`default_nettype none
// ============================================================================
// Module  : tb_argon_regfile_dp
// Brief   : Self-checking bench; 16- and 12-register instances share stimulus
//           and are compared each cycle against an array-based model.
// Revision: 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_argon_regfile_dp;

    localparam int DW = 16;
    localparam int IW = 4;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            sel = 1'b0;
    logic [3*IW-1:0] sel_data = '0;
    logic            ra = 1'b0;
    logic            rb = 1'b0;
    logic            wc = 1'b0;
    logic [DW-1:0]   wr_data = '0;
    logic            clr = 1'b0;

    logic [DW-1:0]   da16, db16, da12, db12;
    logic            va16, vb16, busy16, va12, vb12, busy12;

    int n_total = 0;
    int n_bad   = 0;

    always #5 clk = ~clk;

    argon_regfile_dp #(.DATA_W(DW), .NUM_REGS(16)) dut16 (
        .i_Clk(clk), .i_Reset_n(rst_n), .i_selLatch(sel), .i_selData(sel_data),
        .i_readA(ra), .i_readB(rb), .i_writeC(wc), .i_wrData(wr_data), .i_clear(clr),
        .o_dataA(da16), .o_validA(va16), .o_dataB(db16), .o_validB(vb16), .o_busy(busy16)
    );

    argon_regfile_dp #(.DATA_W(DW), .NUM_REGS(12)) dut12 (
        .i_Clk(clk), .i_Reset_n(rst_n), .i_selLatch(sel), .i_selData(sel_data),
        .i_readA(ra), .i_readB(rb), .i_writeC(wc), .i_wrData(wr_data), .i_clear(clr),
        .o_dataA(da12), .o_validA(va12), .o_dataB(db12), .o_validB(vb12), .o_busy(busy12)
    );

    // Model: instance 0 has 16 registers, instance 1 has 12.
    int mem   [2][16];
    int midx  [2][3];
    int mleft [2];
    int edat  [2][2];
    bit eval  [2][2];

    function automatic int nregs(input int k);
        return (k == 0) ? 16 : 12;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 16; i++) mem[k][i] = 0;
            for (int j = 0; j < 3; j++) midx[k][j] = 0;
            mleft[k] = 0;
            for (int p = 0; p < 2; p++) begin
                edat[k][p] = 0;
                eval[k][p] = 1'b0;
            end
        end
    endtask

    task automatic model_step();
        for (int k = 0; k < 2; k++) begin
            int n;
            n = nregs(k);
            if (mleft[k] > 0) begin
                mem[k][n - mleft[k]] = 0;
                mleft[k]--;
                eval[k][0] = 1'b0;
                eval[k][1] = 1'b0;
            end else if (clr) begin
                mleft[k] = n - 1;
                eval[k][0] = 1'b0;
                eval[k][1] = 1'b0;
            end else begin
                int ci;
                ci = midx[k][2];
                for (int p = 0; p < 2; p++) begin
                    bit rq;
                    int ix, v;
                    rq = (p == 0) ? ra : rb;
                    ix = midx[k][p];
                    if (rq) begin
                        v = (ix != 0 && ix < n) ? mem[k][ix] : 0;
`ifdef ARGON_REGFILE_BYPASS_EN
                        if (wc && ix == ci && ix != 0 && ix < n) v = int'(wr_data);
`endif
                        edat[k][p] = v;
                    end
                    eval[k][p] = rq;
                end
                if (wc && ci != 0 && ci < n) mem[k][ci] = int'(wr_data);
                if (sel) begin
                    midx[k][0] = int'(sel_data[IW-1:0]);
                    midx[k][1] = int'(sel_data[2*IW-1:IW]);
                    midx[k][2] = int'(sel_data[3*IW-1:2*IW]);
                end
            end
        end
    endtask

    function automatic logic [69:0] exp_vec();
        logic [69:0] v;
        v = {mleft[0] > 0, eval[0][0], eval[0][1], DW'(edat[0][0]), DW'(edat[0][1]),
             mleft[1] > 0, eval[1][0], eval[1][1], DW'(edat[1][0]), DW'(edat[1][1])};
        return v;
    endfunction

    function automatic logic [69:0] obs_vec();
        return {busy16, va16, vb16, da16, db16, busy12, va12, vb12, da12, db12};
    endfunction

    task automatic drive(input bit s, input int ic, input int ib, input int ia,
                         input bit a, input bit b, input bit w, input logic [DW-1:0] wd,
                         input bit c);
        sel      = s;
        sel_data = {IW'(ic), IW'(ib), IW'(ia)};
        ra       = a;
        rb       = b;
        wc       = w;
        wr_data  = wd;
        clr      = c;
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0, '0, 0);
    endtask

    task automatic test_reset();
        model_reset();
        #1;
        n_total++;
        if (obs_vec() !== exp_vec()) begin
            n_bad++; $display("FAIL reset_state: got %h want %h", obs_vec(), exp_vec());
        end
        @(negedge clk);
        rst_n = 1'b1;
        drive(0, 0, 0, 0, 1, 1, 0, '0, 0);
        n_total++;
        if (obs_vec() !== exp_vec() || va16 !== 1'b1 || vb16 !== 1'b1 || da16 !== 16'h0) begin
            n_bad++; $display("FAIL reset_read0: got %h want %h", obs_vec(), exp_vec());
        end
        idle();
        n_total++;
        if (obs_vec() !== exp_vec() || va16 !== 1'b0) begin
            n_bad++; $display("FAIL valid_pulse: got %h want %h", obs_vec(), exp_vec());
        end
    endtask

    task automatic test_dual_read();
        drive(1, 3, 3, 3, 0, 0, 0, '0, 0);
        drive(0, 0, 0, 0, 0, 0, 1, 16'hBEEF, 0);
        drive(0, 0, 0, 0, 1, 1, 0, '0, 0);
        n_total++;
        if (obs_vec() !== exp_vec() || da16 !== 16'hBEEF || db16 !== 16'hBEEF
            || va16 !== 1'b1 || vb16 !== 1'b1) begin
            n_bad++; $display("FAIL dual_read: got %h want %h", obs_vec(), exp_vec());
        end
        idle();
        n_total++;
        if (obs_vec() !== exp_vec() || da16 !== 16'hBEEF) begin
            n_bad++; $display("FAIL data_hold: got %h want %h", obs_vec(), exp_vec());
        end
    endtask

    task automatic test_index_bounds();
        drive(1, 0, 0, 0, 0, 0, 0, '0, 0);
        drive(0, 0, 0, 0, 0, 0, 1, 16'h1234, 0);
        drive(0, 0, 0, 0, 1, 0, 0, '0, 0);
        n_total++;
        if (obs_vec() !== exp_vec() || da16 !== 16'h0000) begin
            n_bad++; $display("FAIL idx0_read: got %h want %h", obs_vec(), exp_vec());
        end
        drive(1, 13, 13, 13, 0, 0, 0, '0, 0);
        drive(0, 0, 0, 0, 0, 0, 1, 16'h7777, 0);
        drive(0, 0, 0, 0, 1, 1, 0, '0, 0);
        n_total++;
        if (obs_vec() !== exp_vec() || da16 !== 16'h7777 || da12 !== 16'h0000) begin
            n_bad++; $display("FAIL idx13_oob: got %h want %h", obs_vec(), exp_vec());
        end
    endtask

    task automatic test_bypass();
        drive(1, 5, 5, 5, 0, 0, 0, '0, 0);
        drive(0, 0, 0, 0, 0, 0, 1, 16'h1111, 0);
        drive(0, 0, 0, 0, 1, 0, 1, 16'hA5A5, 0);
        n_total++;
`ifdef ARGON_REGFILE_BYPASS_EN
        if (obs_vec() !== exp_vec() || da16 !== 16'hA5A5) begin
`else
        if (obs_vec() !== exp_vec() || da16 !== 16'h1111) begin
`endif
            n_bad++; $display("FAIL same_cycle_wr_rd: got %h want %h", obs_vec(), exp_vec());
        end
        drive(0, 0, 0, 0, 1, 0, 0, '0, 0);
        n_total++;
        if (obs_vec() !== exp_vec() || da16 !== 16'hA5A5) begin
            n_bad++; $display("FAIL read_after_wr: got %h want %h", obs_vec(), exp_vec());
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 1), $urandom_range(0, 15), $urandom_range(0, 15),
                  $urandom_range(0, 15), $urandom_range(0, 1), $urandom_range(0, 1),
                  $urandom_range(0, 1), DW'($urandom), ($urandom_range(0, 49) == 0));
            n_total++;
            if (obs_vec() !== exp_vec()) begin
                n_bad++; $display("FAIL random_%0d: got %h want %h", i, obs_vec(), exp_vec());
            end
        end
        while (mleft[0] > 0 || mleft[1] > 0) idle();
    endtask

    task automatic test_clear();
        int cnt16, cnt12;
        cnt16 = 0;
        cnt12 = 0;
        for (int i = 1; i < 16; i++) begin
            drive(1, i, i, i, 0, 0, 0, '0, 0);
            drive(0, 0, 0, 0, 0, 0, 1, DW'($urandom_range(1, 16'hFFFF)), 0);
        end
        drive(0, 0, 0, 0, 0, 0, 0, '0, 1);
        for (int i = 0; i < 20; i++) begin
            if (busy16) cnt16++;
            if (busy12) cnt12++;
            n_total++;
            if (obs_vec() !== exp_vec() || (busy16 && va16) || (busy12 && va12)) begin
                n_bad++; $display("FAIL clear_cyc_%0d: got %h want %h", i, obs_vec(), exp_vec());
            end
            drive(0, 0, 0, 0, 1, 1, 0, '0, 0);
        end
        n_total++;
        if (cnt16 != 15 || cnt12 != 11) begin
            n_bad++; $display("FAIL busy_len: got %0d/%0d want 15/11", cnt16, cnt12);
        end
        for (int i = 0; i < 16; i++) begin
            drive(1, i, i, i, 0, 0, 0, '0, 0);
            drive(0, 0, 0, 0, 1, 1, 0, '0, 0);
            n_total++;
            if (obs_vec() !== exp_vec() || da16 !== 16'h0 || db12 !== 16'h0) begin
                n_bad++; $display("FAIL cleared_%0d: got %h want %h", i, obs_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_reset_mid_clear();
        for (int i = 1; i < 8; i++) begin
            drive(1, i, i, i, 0, 0, 0, '0, 0);
            drive(0, 0, 0, 0, 0, 0, 1, DW'($urandom_range(1, 16'hFFFF)), 0);
        end
        drive(0, 0, 0, 0, 0, 0, 0, '0, 1);
        for (int i = 0; i < 3; i++) drive(0, 0, 0, 0, 1, 0, 0, '0, 0);
        n_total++;
        if (busy16 !== 1'b1 || obs_vec() !== exp_vec()) begin
            n_bad++; $display("FAIL pre_abort: got %h want %h", obs_vec(), exp_vec());
        end
        ra = 1'b1;
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        n_total++;
        if (obs_vec() !== exp_vec() || busy16 !== 1'b0 || va16 !== 1'b0) begin
            n_bad++; $display("FAIL async_abort: got %h want %h", obs_vec(), exp_vec());
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 16; i++) begin
            drive(1, i, i, i, 0, 0, 0, '0, 0);
            drive(0, 0, 0, 0, 1, 1, 0, '0, 0);
            n_total++;
            if (obs_vec() !== exp_vec() || da16 !== 16'h0 || busy16 !== 1'b0) begin
                n_bad++; $display("FAIL post_abort_%0d: got %h want %h", i, obs_vec(), exp_vec());
            end
        end
    endtask

    initial begin
        test_reset();
        test_dual_read();
        test_index_bounds();
        test_bypass();
        test_random();
        test_clear();
        test_reset_mid_clear();
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
